ssd_scan: RTL
=============

Name: ssd_scan

Overview:
- Parametrised, time-multiplexed driver for a multi-digit common-anode 7-segment display.
- Supersedes single-digit BCD decoding with:
  - digit scanning;
  - optional hex glyphs;
  - per-digit decimal point and blanking;
  - leading-zero suppression;
  - frame-consistent input snapshotting.
- Sits between datapath counters/registers and the board SSD pins.
- Drives the shared segment bus and the digit-select lines.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- SCAN_CYCLES, 100000, clk cycles each digit stays lit (>=2).
- HEX_EN, 1, 1 = nibbles 10..15 render A,b,C,d,E,F; 0 = render blank.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- value  input  4*DIGITS  digit nibbles; [3:0] = digit 0 (rightmost).
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
- blank  input  DIGITS  force digit dark, 1 = blank.
- lz_en  input  1  leading-zero suppression enable.
- ssd  output  8  segments, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
- ssd_ctl  output  DIGITS  digit select, active-low, one-cold.
- frame_tick  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - ssd = 8'hFF; ssd_ctl = all ones; frame_tick = 0;
  - scan counter = 0; digit index = 0;
  - snapshot registers (value, dp_in, blank, lz_en) = 0.
- Scan counter:
  - Counts 0..SCAN_CYCLES-1, then wraps to 0.
  - On wrap, the digit index increments; DIGITS-1 wraps to 0.
- Frame end:
  - Defined as counter == SCAN_CYCLES-1 and index == DIGITS-1.
  - In that cycle, snapshot registers load the live inputs.
  - frame_tick is high in the following cycle.
  - Live input changes mid-frame never alter the current frame.
- Outputs:
  - ssd and ssd_ctl are registered and computed from the current index and snapshot.
  - They lag an index change by exactly one cycle.
  - ssd_ctl drives bit [index] = 0 and all other bits = 1.
  - After reset deasserts, the next edge drives digit 0 of the zeroed snapshot: ssd = 8'h03, ssd_ctl = ...1110.
- Glyphs, active-low, a..g,dp:
  - 0 = 00000011, 1 = 10011111, 2 = 00100101, 3 = 00001101, 4 = 10011001.
  - 5 = 01001001, 6 = 01000001, 7 = 00011111, 8 = 00000001, 9 = 00001001.
  - A = 00010001, b = 11000001, C = 01100011, d = 10000101, E = 01100001, F = 01110001.
  - HEX_EN = 0: nibbles 10..15 give 11111111 (dark, not all-lit).
- Decimal point: ssd[0] = ~dp_snap[index], applied after glyph lookup, including on otherwise blank digits.
- Blanking: blank_snap[index] = 1 forces ssd[7:1] = 7'h7F; dp still follows dp_snap.
- Leading-zero suppression, when lz_en_snap = 1:
  - A digit k > 0 is suppressed if its nibble and all nibbles above it are 0.
  - Suppressed digits get segments a..g dark; dp unaffected.
  - Digit 0 is never suppressed.
- Digit select during blanking: the digit is still selected (ssd_ctl low); only segments go dark. The duty cycle is therefore unchanged.
- Reset mid-scan: on the next edge all state returns to reset values, with no partial-frame carry-over.
- DIGITS = 1 is not supported. Elaboration asserts DIGITS >= 2 and SCAN_CYCLES >= 2.

Test Plan:
1. Reset and first cycles (DIGITS = 4, SCAN_CYCLES = 4), rst held 3 cycles then released:
   - During reset: ssd = FF, ssd_ctl = 1111.
   - First edge after release: ssd = 03, ssd_ctl = 1110.
   - ssd_ctl rotates 1110→1101→1011→0111 every 4 cycles, then wraps.
2. Snapshot timing: value = 16'h1234 applied mid-frame 0:
   - Frame 0 still shows 0000.
   - frame_tick pulses after cycle 15.
   - Frame 1 shows digit 0 = 4 (10011001) through digit 3 = 1 (10011111).
3. Hex mode, value = 16'hAbCF:
   - HEX_EN = 1: digits 0..3 = 01110001, 01100011, 11000001, 00010001.
   - Rebuilt with HEX_EN = 0: all four digits show 11111111.
4. DP and blank, dp_in = 0101, blank = 0100, value = 16'h8888:
   - digit0 = 00000000;
   - digit1 = 00000001;
   - digit2 = 11111110;
   - digit3 = 00000001.
5. Leading zeros, value = 16'h0070, lz_en = 1:
   - Digits 3 and 2 show 11111111; digit 1 shows 00011111; digit 0 shows 00000011.
   - value = 0 with lz_en = 1: only digit 0 lit, showing 00000011.
6. Mid-scan reset: assert rst at counter = 2, index = 2 → next edge gives ssd = FF, ssd_ctl = 1111, and the scan restarts at digit 0.

Source files
------------

// File: rtl/ssd_scan.sv
// Time-multiplexed driver for a multi-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame so a displayed frame is always self-consistent.
module ssd_scan #(
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 100000,
  parameter bit HEX_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [7:0]            ssd,
  output logic [DIGITS-1:0]     ssd_ctl,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  generate
    if (DIGITS < 2 || SCAN_CYCLES < 2) begin : g_bad_params
      $error("ssd_scan: DIGITS and SCAN_CYCLES must both be >= 2");
    end
  endgenerate

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   value_s;
  logic [DIGITS-1:0]     dp_s;
  logic [DIGITS-1:0]     blank_s;
  logic                  lz_s;

  logic                  cnt_wrap;
  logic                  frame_end;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     sup;
  logic                  zero_above;
  logic [6:0]            seg7;
  logic [7:0]            ssd_nxt;
  logic [DIGITS-1:0]     ctl_nxt;

  // Segment patterns a..g, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = HEX_EN ? 7'b0001000 : 7'h7F;
      4'hB: g = HEX_EN ? 7'b1100000 : 7'h7F;
      4'hC: g = HEX_EN ? 7'b0110001 : 7'h7F;
      4'hD: g = HEX_EN ? 7'b1000010 : 7'h7F;
      4'hE: g = HEX_EN ? 7'b0110000 : 7'h7F;
      default: g = HEX_EN ? 7'b0111000 : 7'h7F;
    endcase
    return g;
  endfunction

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (idx == IDX_LAST);

  always_comb begin
    nib        = value_s[{idx, 2'b00} +: 4];
    sup        = '0;
    zero_above = 1'b1;
    // Walk from the most significant digit down; a digit is a leading zero
    // only while every nibble at or above it is zero. Digit 0 always shows.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (value_s[4*k +: 4] == 4'd0);
      sup[k]     = lz_s && (k != 0) && zero_above;
    end
    seg7    = (blank_s[idx] || sup[idx]) ? 7'h7F : glyph(nib);
    ssd_nxt = {seg7, ~dp_s[idx]};
    ctl_nxt = ~(DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      value_s    <= '0;
      dp_s       <= '0;
      blank_s    <= '0;
      lz_s       <= 1'b0;
      frame_tick <= 1'b0;
      ssd        <= 8'hFF;
      ssd_ctl    <= '1;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (frame_end) begin
        value_s <= value;
        dp_s    <= dp_in;
        blank_s <= blank;
        lz_s    <= lz_en;
      end
      frame_tick <= frame_end;
      ssd        <= ssd_nxt;
      ssd_ctl    <= ctl_nxt;
    end
  end

endmodule
